button_evt_master: RTL and testbench
====================================

// Module: button_evt_master
// PURPOSE
//  Avalon-MM initiator that services the 4-bit button PIO slave (edge-capture + irq_mask regs).
//  Programs irq_mask after reset. On irq it reads edge_capture, clears it, then reads the live
//  level. It pushes one event word {capture, level} into a small FIFO for fabric-side consumers.
//  Sits between the button PIO s1 port and the debounce/UI control logic; replaces CPU ISR polling.
// PARAMETERS
//  DATA_W       4   width of PIO in_port / edge_capture / irq_mask (1..16)
//  FIFO_DEPTH   8   event FIFO entries, power of two (2..64)
//  READ_LATENCY 1   cycles from address presented to m_readdata valid (1..3)
//  MASK_INIT    4'hF  value written to irq_mask (PIO address 2) after reset
// PORTS
//  clk          in   1         system clock
//  reset        in   1         synchronous reset, active-high
//  irq          in   1         PIO irq (|(edge_capture & irq_mask))
//  enable       in   1         1 = service irq; 0 = hold in IDLE
//  m_address    out  2         PIO register address (0 data, 2 irq_mask, 3 edge_capture)
//  m_chipselect out  1         transfer active
//  m_write_n    out  1         0 = write cycle
//  m_writedata  out  32        write data, zero-extended
//  m_readdata   in   32        PIO read data, low DATA_W bits used
//  evt_valid    out  1         FIFO not empty
//  evt_ready    in   1         consumer pop; pop occurs when evt_valid & evt_ready
//  evt_data     out  2*DATA_W  {capture, level} at FIFO head
//  evt_count    out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  overflow     out  1         sticky: an event was dropped because the FIFO was full
//  overflow_clr in   1         clears overflow
// BEHAVIOUR
//  - Reset (sync, active-high): state=INIT, m_chipselect=0, m_write_n=1, m_address=0,
//    m_writedata=0, FIFO emptied, evt_valid=0, evt_count=0, overflow=0, capture/level regs=0.
//    Reset mid-transaction aborts it immediately; no partial event is pushed.
//  - Write cycle: exactly 1 clk with m_chipselect=1, m_write_n=0, m_address/m_writedata stable.
//  - Read cycle: m_chipselect=1, m_write_n=1, address held READ_LATENCY clks; m_readdata sampled
//    on the last of those edges. Between transfers: m_chipselect=0, m_write_n=1.
//  - FSM:
//    INIT    : write MASK_INIT to addr 2 -> IDLE
//    IDLE    : irq & enable -> RD_CAP; otherwise stay
//    RD_CAP  : read addr 3, latch capture -> capture==0 ? IDLE (spurious irq) : CLR_CAP
//    CLR_CAP : write 0 to addr 3 (any write clears all bits) -> RD_LVL
//    RD_LVL  : read addr 0, latch level -> PUSH
//    PUSH    : FIFO full & no same-cycle pop ? set overflow, drop event : write {capture,level}
//              -> IDLE
//  - Service latency from irq rising in IDLE to evt_valid: 2*READ_LATENCY+3 clks (empty FIFO).
//  - Edges arriving between the RD_CAP sample and CLR_CAP are lost; this is a documented
//    limitation of the clear-all PIO.
//  - FIFO: push and pop in the same cycle when full: pop frees an entry and push is accepted.
//    Push and pop in the same cycle when empty: push only, no pop. evt_data is valid only
//    while evt_valid=1. Pointers wrap modulo FIFO_DEPTH.
//  - overflow: set and overflow_clr in the same cycle -> set wins.
//  - enable=0 does not abort an in-flight sequence; it finishes through PUSH.
// CONFIGURATION
//  BUTTON_EVT_TIMESTAMP_EN defined:
//    - Adds a 16-bit free-running cycle counter (reset 0, wraps at 0xFFFF).
//    - The counter value is captured in RD_CAP and stored in the FIFO.
//    - Adds output evt_ts[15:0], aligned with evt_data.
//  BUTTON_EVT_TIMESTAMP_EN undefined: no counter, no evt_ts port, FIFO width 2*DATA_W.
// TESTING
//  1. Release reset -> 1 write cycle addr=2, wdata=0x0000000F, then bus idle.
//  2. PIO model: irq=1, edge_capture=4'b0100, in_port=4'b1011 ->
//     read addr 3, write addr 3 data 0, read addr 0; evt_data=8'h4B, evt_valid=1.
//     Check the cycle count against the latency formula.
//  3. irq=1 with edge_capture=0 -> one read of addr 3, no write, no push, return to IDLE.
//  4. Hold evt_ready=0 and generate 9 events (FIFO_DEPTH=8) -> evt_count=8, overflow=1.
//     Then pulse overflow_clr -> overflow=0.
//  5. FIFO full, PUSH coincides with evt_ready=1 -> event accepted, evt_count stays 8, no overflow.
//  6. Assert reset during RD_LVL -> no push; bus idle next clk; INIT mask write repeats.

Source files
------------

// File: rtl/button_evt_master_if.sv
// Avalon-MM initiator bus between button_evt_master and the button PIO s1 port.
// The master drives address/control/write data; the slave returns read data.
interface button_evt_master_if;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    modport master (
        output m_address, m_chipselect, m_write_n, m_writedata,
        input  m_readdata
    );

    modport slave (
        input  m_address, m_chipselect, m_write_n, m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/button_evt_master.sv
// Button PIO service engine: programs irq_mask, then on irq reads/clears edge_capture,
// reads the live level and queues {capture, level}. BUTTON_EVT_TIMESTAMP_EN adds evt_ts.
module button_evt_master #(
    parameter int                 DATA_W       = 4,
    parameter int                 FIFO_DEPTH   = 8,
    parameter int                 READ_LATENCY = 1,
    parameter logic [DATA_W-1:0]  MASK_INIT    = DATA_W'(4'hF)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          irq,
    input  logic                          enable,
    button_evt_master_if.master           bus,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [2*DATA_W-1:0]           evt_data,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
`ifdef BUTTON_EVT_TIMESTAMP_EN
    output logic [15:0]                   evt_ts,
`endif
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = 2;
`ifdef BUTTON_EVT_TIMESTAMP_EN
    localparam int ENT_W = 2 * DATA_W + 16;
`else
    localparam int ENT_W = 2 * DATA_W;
`endif
    localparam logic [31:0]      MASK_WD  = 32'(MASK_INIT);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_CAP, S_CLR_CAP, S_RD_LVL, S_PUSH
    } state_t;

    state_t             state_q, state_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [1:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [DATA_W-1:0]  cap_q, cap_d;
    logic [DATA_W-1:0]  lvl_q, lvl_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

    logic               push_req, push_ok, pop, full, lat_last;
    logic [DATA_W-1:0]  rd;
    logic [ENT_W-1:0]   entry;
    logic               unused_rd;

    assign rd        = bus.m_readdata[DATA_W-1:0];
    assign unused_rd = ^bus.m_readdata[31:DATA_W];
    assign lat_last  = (lat_q == LAT_END);

`ifdef BUTTON_EVT_TIMESTAMP_EN
    logic [15:0] ts_q, ts_cap_q, ts_cap_d;
    assign entry  = {ts_cap_q, cap_q, lvl_q};
    assign evt_ts = mem_q[rd_ptr_q][ENT_W-1 -: 16];
`else
    assign entry  = {cap_q, lvl_q};
`endif

    always_comb begin
        state_d  = state_q;
        cs_d     = 1'b0;
        wn_d     = 1'b1;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        cap_d    = cap_q;
        lvl_d    = lvl_q;
        push_req = 1'b0;
`ifdef BUTTON_EVT_TIMESTAMP_EN
        ts_cap_d = ts_cap_q;
`endif
        unique case (state_q)
            S_INIT: begin
                // First cycle raises the write; second cycle ends it.
                if (!cs_q) begin
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = 2'd2;
                    wdata_d = MASK_WD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (irq && enable) begin
                    state_d = S_RD_CAP;
                    cs_d    = 1'b1;
                    addr_d  = 2'd3;
                    lat_d   = '0;
                end
            end
            S_RD_CAP: begin
                if (lat_last) begin
                    cap_d = rd;
`ifdef BUTTON_EVT_TIMESTAMP_EN
                    ts_cap_d = ts_q;
`endif
                    if (rd == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CLR_CAP;
                        cs_d    = 1'b1;
                        wn_d    = 1'b0;
                        addr_d  = 2'd3;
                        wdata_d = '0;
                    end
                end else begin
                    cs_d  = 1'b1;
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_CLR_CAP: begin
                state_d = S_RD_LVL;
                cs_d    = 1'b1;
                addr_d  = 2'd0;
                lat_d   = '0;
            end
            S_RD_LVL: begin
                if (lat_last) begin
                    lvl_d   = rd;
                    state_d = S_PUSH;
                end else begin
                    cs_d  = 1'b1;
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_PUSH: begin
                push_req = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    always_comb begin
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        pop      = (count_q != '0) && evt_ready;
        push_ok  = push_req && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = overflow_clr ? 1'b0 : ovf_q;
        if (push_req && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_INIT;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_q    <= '0;
            cap_q    <= '0;
            lvl_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            cap_q    <= cap_d;
            lvl_q    <= lvl_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef BUTTON_EVT_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q     <= '0;
            ts_cap_q <= '0;
        end else begin
            ts_q     <= ts_q + 16'd1;
            ts_cap_q <= ts_cap_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem_q[wr_ptr_q] <= entry;
    end

    assign bus.m_address    = addr_q;
    assign bus.m_chipselect = cs_q;
    assign bus.m_write_n    = wn_q;
    assign bus.m_writedata  = wdata_q;
    assign evt_valid        = (count_q != '0);
    assign evt_data         = mem_q[rd_ptr_q][2*DATA_W-1:0];
    assign evt_count        = count_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_button_evt_master.sv
// Scoreboard bench for button_evt_master with a behavioural button PIO model.
// Expected events are queued at stimulus time and checked by a separate pop monitor.
module tb_button_evt_master;

    logic        clk = 1'b0;
    logic        reset, irq, enable, evt_ready, overflow_clr;
    logic        evt_valid, overflow;
    logic [7:0]  evt_data;
    logic [3:0]  evt_count;
`ifdef BUTTON_EVT_TIMESTAMP_EN
    logic [15:0] evt_ts;
`endif

    button_evt_master_if bus ();

    button_evt_master dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .enable       (enable),
        .bus          (bus),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_count    (evt_count),
`ifdef BUTTON_EVT_TIMESTAMP_EN
        .evt_ts       (evt_ts),
`endif
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    // PIO model
    logic [3:0]  edge_cap = 4'h0;
    logic [3:0]  in_port  = 4'h0;
    logic [3:0]  mask     = 4'h0;
    logic        irq_force = 1'b0;
    int          n_wr_mask = 0, n_wr_clr = 0, n_rd_cap = 0, n_rd_lvl = 0;
    logic [31:0] last_clr = 32'hFFFF_FFFF;
    logic [31:0] last_mask = 32'h0;

    assign irq = (|(edge_cap & mask)) | irq_force;
    assign bus.m_readdata =
        !(bus.m_chipselect && bus.m_write_n) ? 32'h0 :
        (bus.m_address == 2'd3) ? {28'h0, edge_cap} :
        (bus.m_address == 2'd0) ? {28'h0, in_port} :
        (bus.m_address == 2'd2) ? {28'h0, mask} : 32'h0;

    always @(negedge clk) begin
        if (bus.m_chipselect) begin
            if (!bus.m_write_n) begin
                if (bus.m_address == 2'd2) begin
                    n_wr_mask++;
                    last_mask = bus.m_writedata;
                    mask = bus.m_writedata[3:0];
                end else if (bus.m_address == 2'd3) begin
                    n_wr_clr++;
                    last_clr = bus.m_writedata;
                    edge_cap = 4'h0;
                end
            end else if (bus.m_address == 2'd3) begin
                n_rd_cap++;
            end else if (bus.m_address == 2'd0) begin
                n_rd_lvl++;
            end
        end
    end

    // Scoreboard monitor
    logic [7:0] exp_q[$];
    int         n_popped = 0;

    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            n_popped++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL evt_pop: got %0h with nothing expected", evt_data);
            end else begin
                check("evt_pop", {24'h0, evt_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic start_event(input logic [3:0] c, input logic [3:0] l,
                               input bit expect_push);
        @(posedge clk);
        #1;
        in_port  = l;
        edge_cap = c;
        if (expect_push) exp_q.push_back({c, l});
    endtask

    task automatic wait_rd_lvl(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.m_chipselect && bus.m_write_n && bus.m_address == 2'd0)
                seen = 1'b1;
        end
        if (!seen) timeout(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, c0, w0, l0, m0, cnt0;
        reset = 1'b1; enable = 1'b1; evt_ready = 1'b0; overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", {31'h0, bus.m_chipselect}, 32'h0);
        check("rst_wn", {31'h0, bus.m_write_n}, 32'h1);
        check("rst_addr", {30'h0, bus.m_address}, 32'h0);
        check("rst_wdata", bus.m_writedata, 32'h0);
        check("rst_valid", {31'h0, evt_valid}, 32'h0);
        check("rst_count", {28'h0, evt_count}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);

        // 1: mask programming after reset
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("init_wr_cnt", n_wr_mask, 1);
        check("init_wdata", last_mask, 32'h0000_000F);
        check("init_idle", {31'h0, bus.m_chipselect}, 32'h0);

        // 2: single event and service latency
        c0 = n_rd_cap; w0 = n_wr_clr; l0 = n_rd_lvl;
        start_event(4'b0100, 4'b1011, 1'b1);
        lat = 0;
        while (!evt_valid && lat < 20) begin
            @(posedge clk); lat++; #1;
        end
        if (!evt_valid) timeout("evt2_valid");
        check("latency", lat, 5);
        @(negedge clk);
        check("evt2_data", {24'h0, evt_data}, 32'h4B);
        check("evt2_rdcap", n_rd_cap - c0, 1);
        check("evt2_clr", n_wr_clr - w0, 1);
        check("evt2_clr_data", last_clr, 32'h0);
        check("evt2_rdlvl", n_rd_lvl - l0, 1);
        @(posedge clk); #1 evt_ready = 1'b1;
        @(posedge clk); #1 evt_ready = 1'b0;
        check("evt2_drained", {28'h0, evt_count}, 32'h0);

        // 3: spurious irq
        c0 = n_rd_cap; w0 = n_wr_clr; l0 = n_rd_lvl;
        @(posedge clk); #1 irq_force = 1'b1;
        @(posedge clk); #1 irq_force = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("spur_rdcap", n_rd_cap - c0, 1);
        check("spur_clr", n_wr_clr - w0, 0);
        check("spur_rdlvl", n_rd_lvl - l0, 0);
        check("spur_count", {28'h0, evt_count}, 32'h0);

        // 4: fill to overflow
        for (int i = 0; i < 9; i++) begin
            start_event(4'(i + 1), 4'(15 - i), i < 8);
            repeat (8) @(posedge clk);
        end
        @(negedge clk);
        check("full_count", {28'h0, evt_count}, 32'h8);
        check("ovf_set", {31'h0, overflow}, 32'h1);
        @(posedge clk); #1 overflow_clr = 1'b1;
        @(posedge clk); #1 overflow_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr", {31'h0, overflow}, 32'h0);
        check("ovf_clr_count", {28'h0, evt_count}, 32'h8);

        // 5: push into full FIFO with same-cycle pop
        start_event(4'hA, 4'h3, 1'b1);
        wait_rd_lvl("t5_rd_lvl");
        @(posedge clk); #1 evt_ready = 1'b1;
        @(posedge clk); #1 evt_ready = 1'b0;
        @(negedge clk);
        check("pp_count", {28'h0, evt_count}, 32'h8);
        check("pp_ovf", {31'h0, overflow}, 32'h0);
        check("pp_popped", n_popped, 2);
        @(posedge clk); #1 evt_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_q", exp_q.size(), 0);
        check("drain_count", {28'h0, evt_count}, 32'h0);

        // enable=0 holds off service
        c0 = n_rd_cap;
        @(posedge clk); #1 enable = 1'b0;
        start_event(4'b0010, 4'b0101, 1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("en0_hold", n_rd_cap - c0, 0);
        @(posedge clk); #1 enable = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("en1_served", exp_q.size(), 0);
        check("en1_rdcap", n_rd_cap - c0, 1);
        @(posedge clk); #1 evt_ready = 1'b0;

        // 6: reset during RD_LVL
        m0 = n_wr_mask;
        cnt0 = n_popped;
        start_event(4'b0001, 4'b0110, 1'b0);
        wait_rd_lvl("t6_rd_lvl");
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_cs", {31'h0, bus.m_chipselect}, 32'h0);
        check("abort_count", {28'h0, evt_count}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_remask", n_wr_mask - m0, 1);
        check("abort_nopush", {28'h0, evt_count}, 32'h0);
        check("abort_valid", {31'h0, evt_valid}, 32'h0);
        check("abort_pops", n_popped - cnt0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
